// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state encodings, result width and step count shared by the divider files
package div_unit_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
`ifdef DIV_ZERO_FAST_EN
        DIV_DIVZERO = 2'b01,
`endif
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;
    localparam int DIV_RESULT_WD = 64;
    localparam int DIV_STEPS = 32;
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage request/result bundle between the pipeline and the divider
interface div_unit_if;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
    modport master (output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
                    input result_o, ready_o, stallreq_o);
    modport slave (input start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
                   output result_o, ready_o, stallreq_o);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift-compare-subtract iteration on the 65-bit working register
module div_step (
    input  logic [64:0] w_in,
    input  logic [31:0] divisor,
    output logic [64:0] w_out
);
    logic        ge;
    logic [31:0] rem;
    // w[64:32] holds the shifted partial remainder; quotient bits enter at bit 0
    always_comb begin
        ge = w_in[64:32] >= {1'b0, divisor};
        rem = ge ? 32'(w_in[64:32] - {1'b0, divisor}) : w_in[63:32];
        w_out = {rem, w_in[31:0], ge};
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned multi-cycle divider; DIV_ZERO_FAST_EN enables the short divide-by-zero path
module div_unit import div_unit_pkg::*; (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    div_state_t                 state, state_n;
    logic [5:0]                 cnt;
    logic [64:0]                w, w_nxt;
    logic [31:0]                dvs_q, op1_q, q_fix, r_fix;
    logic                       dvd_neg_q, dvs_neg_q, zero_q, ready_q;
    logic [DIV_RESULT_WD-1:0]   result_q, fin;

    div_step u_step (.w_in(w), .divisor(dvs_q), .w_out(w_nxt));

    assign q_fix = (dvd_neg_q ^ dvs_neg_q) ? -w[31:0] : w[31:0];
    assign r_fix = dvd_neg_q ? -w[64:33] : w[64:33];
    assign fin = zero_q ? {op1_q, 32'hFFFFFFFF} : {r_fix, q_fix};
    assign bus.result_o = result_q;
    assign bus.ready_o = ready_q;
    assign bus.stallreq_o = rst & bus.start_i & ~ready_q & ~bus.annul_i;

    // state register
    always_ff @(posedge clk)
        state <= !rst ? DIV_IDLE : state_n;

    // next state; annul always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
`ifdef DIV_ZERO_FAST_EN
            DIV_IDLE:    if (bus.start_i) state_n = (bus.opdata2_i == '0) ? DIV_DIVZERO : DIV_ON;
            DIV_DIVZERO: state_n = DIV_END;
`else
            DIV_IDLE:    if (bus.start_i) state_n = DIV_ON;
`endif
            DIV_ON:      if (cnt == 6'(DIV_STEPS)) state_n = DIV_END;
            DIV_END:     if (!bus.start_i) state_n = DIV_IDLE;
            default:     state_n = DIV_IDLE;
        endcase
        if (bus.annul_i) state_n = DIV_IDLE;
    end

    // operand latch, iteration counter, sign fix-up and result registers
    always_ff @(posedge clk) begin
        if (!rst || bus.annul_i) begin
            cnt <= '0;
            ready_q <= 1'b0;
            result_q <= '0;
            if (!rst) w <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (bus.start_i) begin
                    op1_q <= bus.opdata1_i;
                    dvs_q <= abs32(bus.opdata2_i, bus.signed_div_i);
                    dvd_neg_q <= bus.signed_div_i & bus.opdata1_i[31];
                    dvs_neg_q <= bus.signed_div_i & bus.opdata2_i[31];
                    zero_q <= bus.opdata2_i == '0;
                    w <= {32'b0, abs32(bus.opdata1_i, bus.signed_div_i), 1'b0};
                    cnt <= '0;
                end
`ifdef DIV_ZERO_FAST_EN
                DIV_DIVZERO: begin
                    result_q <= {op1_q, 32'hFFFFFFFF};
                    ready_q <= 1'b1;
                end
`endif
                DIV_ON: if (cnt == 6'(DIV_STEPS)) begin
                    result_q <= fin;
                    ready_q <= 1'b1;
                end else begin
                    w <= w_nxt;
                    cnt <= cnt + 6'd1;
                end
                DIV_END: if (!bus.start_i) begin
                    ready_q <= 1'b0;
                    result_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start_i, input, 1 bit: division request, held high by EX until ready_o is seen.
REQ-004 SHALL have port signed_div_i, input, 1 bit: 1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have ports opdata1_i and opdata2_i, input, 32 bits each: dividend and divisor.
REQ-006 SHALL have port annul_i, input, 1 bit: pipeline flush; abort the current operation.
REQ-007 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}.
REQ-008 SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-009 SHALL have port stallreq_o, output, 1 bit: stall request to the pipeline controller.

Function
REQ-010 SHALL implement the FSM states IDLE, DIVZERO, ON and END.
REQ-011 In IDLE, start_i=1 and annul_i=0 SHALL latch the operands and signed_div_i, clear the step counter, and go to ON; if divisor=0 (with DIV_ZERO_FAST_EN) it SHALL go to DIVZERO instead.
REQ-012 In IDLE, the latched dividend and divisor SHALL be two's-complement absolute values when signed_div_i=1 and the operand is negative; otherwise unchanged.
REQ-013 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register, for exactly 32 cycles (counter 0..31), then go to END.
REQ-014 On the ON->END edge, the quotient SHALL be negated if signed and the operand signs differ; the remainder SHALL be negated if signed and the dividend is negative; both SHALL be registered into result_o.
REQ-015 DIVZERO SHALL load result_o = {opdata1 latched, 32'hFFFFFFFF} and go to END on the next edge.
REQ-016 END SHALL drive ready_o=1 and hold result_o, and SHALL stay in END while start_i=1.
REQ-017 When start_i=0 in END, the FSM SHALL return to IDLE with ready_o=0 and result_o=0.
REQ-018 Latency: ready_o SHALL rise 34 edges after start_i is sampled in IDLE (2 edges via DIVZERO).
REQ-019 stallreq_o SHALL equal start_i AND NOT ready_o, combinationally, and SHALL be 0 when annul_i=1.
REQ-020 annul_i=1 in any state SHALL force the next state to IDLE with ready_o=0, result_o=0 and the counter cleared; annul_i SHALL take priority over start_i.
REQ-021 Operand changes while in ON, DIVZERO or END SHALL be ignored.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap; no trap).

Reset
REQ-023 rst=0 at an edge SHALL force IDLE, ready_o=0, result_o=0, counter=0 and working register=0, including mid-ON.
REQ-024 stallreq_o SHALL be 0 during reset regardless of start_i.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN: when defined, divisor=0 SHALL take the DIVZERO path (ready_o after 2 edges).
REQ-026 When DIV_ZERO_FAST_EN is undefined, DIVZERO SHALL not exist and divisor=0 SHALL run the full 32 steps (34 edges), with END forced to {dividend, 32'hFFFFFFFF}.
REQ-027 result_o SHALL be identical in both builds for every input; only latency differs.

Structure
REQ-028 The shared defines file SHALL hold the state encodings (DIV_IDLE, DIV_DIVZERO, DIV_ON, DIV_END), DIV_RESULT_WD=64 and DIV_STEPS=32.
REQ-029 A combinational sub-module div_step SHALL implement one shift-compare-subtract iteration (65-bit in and out).
REQ-030 The FSM, counter, sign fix-up and output registers SHALL reside in div_unit.

Verification
REQ-031 DIVU 100/7, start held -> ready_o at edge 34, result_o = {0x00000002, 0x0000000E}; start dropped -> IDLE next edge.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}, no hang.
REQ-034 DIVU 5/0 -> {0x00000005, 0xFFFFFFFF}; ready at edge 2 with DIV_ZERO_FAST_EN, edge 34 without.
REQ-035 annul_i pulsed at ON step 10 -> IDLE next edge, ready_o never rises; a new start_i then completes normally.
REQ-036 rst low during ON step 20 -> IDLE with result_o=0; stallreq_o=0 while rst is low.
